// File: rtl/red_pitaya_daisy_pkg.sv
// Shared constants and FSM encoding for the daisy-chain transmit serializer.
package red_pitaya_daisy_pkg;

  localparam int unsigned DAISY_DW    = 16;
  localparam int unsigned BIT_CW      = 5;
  localparam int unsigned GAP_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_PAR,
    ST_GAP
  } daisy_st_t;

endpackage

// File: rtl/red_pitaya_daisy_fifo.sv
// Small synchronous FIFO buffering parallel words ahead of the serializer.
module red_pitaya_daisy_fifo
  import red_pitaya_daisy_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push,
  input  logic                pop,
  input  logic [DAISY_DW-1:0] din,
  output logic [DAISY_DW-1:0] dout,
  output logic                full,
  output logic                empty,
  output logic [AW:0]         count
);

  logic [DAISY_DW-1:0] mem [2**AW];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  // count never exceeds the depth, so its MSB alone marks "full"
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/red_pitaya_daisy_tx_ser.sv
// Daisy-chain transmit serializer: buffers 16-bit words and emits framed,
// even-parity serial bits, MSB first, with a fixed idle gap between frames.
module red_pitaya_daisy_tx_ser
  import red_pitaya_daisy_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_dv_i,
  input  logic [DAISY_DW-1:0] tx_dat_i,
  output logic                tx_rdy_o,
  input  logic                ser_en_i,
  output logic                ser_dat_o,
  output logic                ser_frm_o,
  input  logic                stat_clr_i,
  output logic [31:0]         stat_frm_o,
  output logic                stat_ovf_o
);

  localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  daisy_st_t           state;
  daisy_st_t           state_nxt;
  logic [DAISY_DW-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_AW:0]    fifo_cnt;
  logic                fifo_push;
  logic                fifo_pop;
  logic [DAISY_DW-1:0] shift_q;
  logic                par_q;
  logic [BIT_CW-1:0]   bit_cnt;
  logic [3:0]          gap_cnt;
  logic [31:0]         frm_cnt;
  logic                ovf_q;
  logic                frm_done;
  logic                ovf_evt;

  assign tx_rdy_o   = (fifo_cnt != FIFO_DEPTH);
  assign fifo_push  = tx_dv_i & tx_rdy_o;
  assign ovf_evt    = tx_dv_i & fifo_full;
  assign stat_frm_o = frm_cnt;
  assign stat_ovf_o = ovf_q;

  red_pitaya_daisy_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_dat_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    frm_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ser_en_i && !fifo_empty) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt == BIT_CW'(DAISY_DW - 1)) begin
          state_nxt = ST_PAR;
        end
      end
      ST_PAR: begin
        frm_done  = 1'b1;
        state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == 4'(GAP_CYC - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Serial outputs are registered from the current state, so each state's
  // bit appears on the pins one cycle after the state is entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_dat_o <= 1'b0;
      ser_frm_o <= 1'b0;
    end else begin
      ser_dat_o <= 1'b0;
      ser_frm_o <= 1'b0;
      case (state)
        ST_LOAD: begin
          shift_q <= fifo_dout;
          par_q   <= ^fifo_dout;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          ser_dat_o <= shift_q[DAISY_DW-1];
          ser_frm_o <= 1'b1;
          shift_q   <= shift_q << 1;
          bit_cnt   <= bit_cnt + 1'b1;
        end
        ST_PAR: begin
          ser_dat_o <= par_q;
          gap_cnt   <= '0;
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clear beats a coincident frame increment; a new overflow beats clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frm_cnt <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (stat_clr_i) begin
        frm_cnt <= '0;
      end else if (frm_done) begin
        frm_cnt <= frm_cnt + 32'd1;
      end
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end else if (stat_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule
